// File: rtl/conv_pkg.sv
// Shared widths and state encoding for the convolution controller and the
// multiplier pool allocator.
package conv_pkg;

    localparam int NMULT = 64;
    localparam int MMULT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        GRANT = 2'd2,
        DENY  = 2'd3
    } alloc_state_e;

endpackage : conv_pkg

// File: rtl/mult_pool_alloc_if.sv
// Request / grant / release bundle between the convolution controller (master)
// and the multiplier pool allocator (slave).
interface mult_pool_alloc_if #(
    parameter int NMULT = conv_pkg::NMULT,
    parameter int MMULT = conv_pkg::MMULT
);

    logic             req_valid;
    logic [MMULT:0]   req_count;
    logic             req_ready;
    logic             grant_valid;
    logic             grant_ready;
    logic [MMULT-1:0] grant_idx;
    logic             grant_last;
    logic             deny;
    logic             rel_valid;
    logic [MMULT-1:0] rel_idx;
    logic             rel_err;
    logic [NMULT-1:0] mult_loc;
    logic [MMULT:0]   free_cnt;

    modport master (
        output req_valid, req_count, grant_ready, rel_valid, rel_idx,
        input  req_ready, grant_valid, grant_idx, grant_last, deny,
               rel_err, mult_loc, free_cnt
    );

    modport slave (
        input  req_valid, req_count, grant_ready, rel_valid, rel_idx,
        output req_ready, grant_valid, grant_idx, grant_last, deny,
               rel_err, mult_loc, free_cnt
    );

endinterface : mult_pool_alloc_if

// File: rtl/mult_prio_enc.sv
// Lowest-index zero-bit search over the occupancy bitmap.
module mult_prio_enc #(
    parameter int NMULT = conv_pkg::NMULT,
    parameter int MMULT = conv_pkg::MMULT
) (
    input  logic [NMULT-1:0] bitmap,
    output logic [MMULT-1:0] idx,
    output logic             found
);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scanning downward lets the lowest free index be the last one written.
        for (int i = NMULT - 1; i >= 0; i--) begin
            if (!bitmap[i]) begin
                idx   = MMULT'(i);
                found = 1'b1;
            end
        end
    end

endmodule : mult_prio_enc

// File: rtl/mult_pool_alloc.sv
// Multiplier pool allocator: grants one free multiplier per handshake for a
// counted request, and accepts releases in any state.
module mult_pool_alloc #(
    parameter int NMULT = conv_pkg::NMULT,
    parameter int MMULT = conv_pkg::MMULT
) (
    input  logic             clk,
    input  logic             rstn,
    mult_pool_alloc_if.slave bus
);

    import conv_pkg::*;

    alloc_state_e     state_q, state_d;
    logic [MMULT:0]   rem_q, rem_d;
    logic [NMULT-1:0] mult_loc_q, mult_loc_d;
    logic [MMULT:0]   free_cnt_q, free_cnt_d;
    logic             rel_err_q, rel_err_d;

    logic [MMULT-1:0] enc_idx;
    logic             enc_found;
    logic             req_fire;
    logic             grant_fire;
    logic             rel_in_range;
    logic             rel_hit;

    mult_prio_enc #(
        .NMULT (NMULT),
        .MMULT (MMULT)
    ) u_prio_enc (
        .bitmap (mult_loc_q),
        .idx    (enc_idx),
        .found  (enc_found)
    );

    assign req_fire     = (state_q == IDLE) && bus.req_valid;
    assign grant_fire   = (state_q == GRANT) && enc_found && bus.grant_ready;
    assign rel_in_range = (int'(bus.rel_idx) < NMULT);
    assign rel_hit      = bus.rel_valid && rel_in_range && mult_loc_q[bus.rel_idx];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            mult_loc_q <= '0;
            free_cnt_q <= (MMULT + 1)'(NMULT);
            rel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            mult_loc_q <= mult_loc_d;
            free_cnt_q <= free_cnt_d;
            rel_err_q  <= rel_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.req_valid) state_d = CHECK;
            CHECK: state_d = (rem_q != '0 && rem_q <= free_cnt_q) ? GRANT : DENY;
            GRANT: if (grant_fire && rem_q == (MMULT + 1)'(1)) state_d = IDLE;
            DENY:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant and release both act on the pre-edge bitmap; the granted bit is
    // free so it can never collide with a valid release.
    always_comb begin
        rem_d      = rem_q;
        mult_loc_d = mult_loc_q;
        free_cnt_d = free_cnt_q + (MMULT + 1)'(rel_hit) - (MMULT + 1)'(grant_fire);
        rel_err_d  = bus.rel_valid && !rel_hit;
        if (req_fire) begin
            rem_d = bus.req_count;
        end else if (grant_fire) begin
            rem_d = rem_q - (MMULT + 1)'(1);
        end
        if (grant_fire) begin
            mult_loc_d[enc_idx] = 1'b1;
        end
        if (rel_hit) begin
            mult_loc_d[bus.rel_idx] = 1'b0;
        end
    end

    always_comb begin
        bus.req_ready   = (state_q == IDLE);
        bus.grant_valid = (state_q == GRANT) && enc_found;
        bus.grant_last  = (state_q == GRANT) && (rem_q == (MMULT + 1)'(1));
        bus.grant_idx   = enc_idx;
        bus.deny        = (state_q == DENY);
        bus.rel_err     = rel_err_q;
        bus.mult_loc    = mult_loc_q;
        bus.free_cnt    = free_cnt_q;
    end

endmodule : mult_pool_alloc

// File: tb/tb_mult_pool_alloc.sv
// Scenario bench for mult_pool_alloc: expected grants are queued when a request
// is issued and compared as the allocator hands them out.
module tb_mult_pool_alloc;

    typedef struct {
        logic [5:0] idx;
        logic       last;
    } grant_t;

    logic clk;
    logic rstn;
    int   errors = 0;
    int   checks = 0;
    grant_t exp_q[$];

    mult_pool_alloc_if bus ();

    mult_pool_alloc dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int idx, input logic last);
        grant_t g;
        g.idx  = 6'(idx);
        g.last = last;
        exp_q.push_back(g);
    endtask

    // Waits for IDLE, presents the request for one edge and returns at the
    // falling edge after acceptance (allocator now in CHECK).
    task automatic send_req(input logic [6:0] cnt);
        int b = 0;
        @(negedge clk);
        while (!bus.req_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk("req_ready_before_req", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_count = cnt;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("check_state_no_grant", 64'(bus.grant_valid), 64'd0);
        chk("check_state_no_ready", 64'(bus.req_ready), 64'd0);
    endtask

    // Drains the expected-grant queue. Optionally releases rel_i together with
    // handshake rel_at, and withholds grant_ready for stall_n cycles at grant stall_at.
    task automatic consume(input int rel_at, input logic [5:0] rel_i,
                           input int stall_at, input int stall_n, output int cycles);
        int n = 0;
        int stalled = 0;
        int budget = 0;
        logic [63:0] snap = '0;
        grant_t e;
        while (exp_q.size() > 0 && budget < 400) begin
            @(negedge clk);
            budget++;
            bus.rel_valid = 1'b0;
            if (bus.grant_valid) begin
                e = exp_q[0];
                checks++;
                if (bus.grant_idx !== e.idx || bus.grant_last !== e.last) begin
                    errors++;
                    $display("FAIL grant_%0d: got idx=%0d last=%0b expected idx=%0d last=%0b",
                             n, bus.grant_idx, bus.grant_last, e.idx, e.last);
                end
                if (n == stall_at && stalled < stall_n) begin
                    if (stalled == 0) snap = bus.mult_loc;
                    else chk("stall_mult_loc_held", bus.mult_loc, snap);
                    bus.grant_ready = 1'b0;
                    stalled++;
                end else begin
                    if (n == stall_at && stalled > 0) chk("stall_release_mult_loc", bus.mult_loc, snap);
                    bus.grant_ready = 1'b1;
                    void'(exp_q.pop_front());
                    if (n == rel_at) begin
                        bus.rel_valid = 1'b1;
                        bus.rel_idx   = rel_i;
                    end
                    n++;
                end
            end else if (n == stall_at && stalled > 0) begin
                chk("stall_grant_valid_held", 64'(bus.grant_valid), 64'd1);
            end
        end
        cycles = budget;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got %0d grants, %0d still expected", n, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        bus.rel_valid   = 1'b0;
        bus.grant_ready = 1'b1;
    endtask

    task automatic test_reset();
        rstn            = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_count   = '0;
        bus.grant_ready = 1'b1;
        bus.rel_valid   = 1'b0;
        bus.rel_idx     = '0;
        repeat (3) @(negedge clk);
        chk("reset_mult_loc", bus.mult_loc, 64'd0);
        chk("reset_free_cnt", 64'(bus.free_cnt), 64'd64);
        chk("reset_grant_valid", 64'(bus.grant_valid), 64'd0);
        chk("reset_deny_rel_err", {62'd0, bus.deny, bus.rel_err}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic test_basic_grant();
        int cyc;
        send_req(7'd3);
        push(0, 1'b0);
        push(1, 1'b0);
        push(2, 1'b1);
        consume(-1, 6'd0, -1, 0, cyc);
        chk("basic_consecutive_cycles", 64'(cyc), 64'd3);
        chk("basic_mult_loc", bus.mult_loc, 64'h7);
        chk("basic_free_cnt", 64'(bus.free_cnt), 64'd61);
        chk("basic_back_to_idle", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic test_deny(input logic [6:0] cnt, input logic [63:0] loc, input logic [6:0] free);
        send_req(cnt);
        @(negedge clk);
        chk("deny_pulse", 64'(bus.deny), 64'd1);
        chk("deny_no_grant", 64'(bus.grant_valid), 64'd0);
        @(negedge clk);
        chk("deny_one_cycle", 64'(bus.deny), 64'd0);
        chk("deny_req_ready", 64'(bus.req_ready), 64'd1);
        chk("deny_mult_loc", bus.mult_loc, loc);
        chk("deny_free_cnt", 64'(bus.free_cnt), 64'(free));
    endtask

    task automatic test_release_mid_stream();
        int cyc;
        send_req(7'd3);
        push(3, 1'b0);
        push(1, 1'b0);
        push(4, 1'b1);
        consume(0, 6'd1, -1, 0, cyc);
        chk("relgrant_mult_loc", bus.mult_loc, 64'h1F);
        chk("relgrant_free_cnt", 64'(bus.free_cnt), 64'd59);
    endtask

    task automatic test_rel_err();
        @(negedge clk);
        bus.rel_valid = 1'b1;
        bus.rel_idx   = 6'd5;
        @(negedge clk);
        bus.rel_valid = 1'b0;
        chk("rel_err_pulse", 64'(bus.rel_err), 64'd1);
        chk("rel_err_mult_loc", bus.mult_loc, 64'h1F);
        @(negedge clk);
        chk("rel_err_one_cycle", 64'(bus.rel_err), 64'd0);
        bus.rel_valid = 1'b1;
        bus.rel_idx   = 6'd2;
        @(negedge clk);
        bus.rel_valid = 1'b0;
        chk("rel_ok_no_err", 64'(bus.rel_err), 64'd0);
        chk("rel_ok_mult_loc", bus.mult_loc, 64'h1B);
        chk("rel_ok_free_cnt", 64'(bus.free_cnt), 64'd60);
    endtask

    task automatic test_stall();
        int cyc;
        send_req(7'd3);
        push(2, 1'b0);
        push(5, 1'b0);
        push(6, 1'b1);
        consume(-1, 6'd0, 1, 4, cyc);
        chk("stall_cycles", 64'(cyc), 64'd7);
        chk("stall_mult_loc", bus.mult_loc, 64'h7F);
        chk("stall_free_cnt", 64'(bus.free_cnt), 64'd57);
    endtask

    task automatic test_reset_mid_grant();
        int cyc;
        send_req(7'd4);
        @(negedge clk);
        chk("midrst_grant0", 64'(bus.grant_idx), 64'd7);
        @(negedge clk);
        chk("midrst_grant1", 64'(bus.grant_idx), 64'd8);
        @(negedge clk);
        chk("midrst_partial_loc", bus.mult_loc, 64'h1FF);
        rstn = 1'b0;
        #1;
        chk("midrst_mult_loc", bus.mult_loc, 64'd0);
        chk("midrst_free_cnt", 64'(bus.free_cnt), 64'd64);
        chk("midrst_grant_valid", 64'(bus.grant_valid), 64'd0);
        chk("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        rstn = 1'b1;
        send_req(7'd64);
        for (int i = 0; i < 64; i++) push(i, i == 63);
        consume(-1, 6'd0, -1, 0, cyc);
        chk("full_mult_loc", bus.mult_loc, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("full_free_cnt", 64'(bus.free_cnt), 64'd0);
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_deny(7'd62, 64'h7, 7'd61);
        test_deny(7'd0, 64'h7, 7'd61);
        test_release_mid_stream();
        test_rel_err();
        test_stall();
        test_reset_mid_grant();
        test_deny(7'd1, 64'hFFFF_FFFF_FFFF_FFFF, 7'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mult_pool_alloc
